// File: rtl/shared_bus_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin bus arbiter:
// data width, FSM state encoding and small helpers.
package shared_bus_arbiter_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  // True when the beat about to be accepted is the last one the grant may carry.
  function automatic logic burst_full(input logic [7:0] cnt, input logic [7:0] last_idx);
    return (cnt == last_idx);
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// Requester and downstream signals of the shared bus arbiter.
// The arbiter uses the slave view; requesters/sink drive the master view.
interface shared_bus_arbiter_if;
  import shared_bus_arbiter_pkg::*;

  logic              valid0;
  logic              valid1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              last0;
  logic              last1;
  logic              ready0;
  logic              ready1;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_last;

  modport slave (
    input  valid0, valid1, data0, data1, last0, last1, out_ready,
    output ready0, ready1, out_valid, out_data, out_src, out_last
  );

  modport master (
    output valid0, valid1, data0, data1, last0, last1, out_ready,
    input  ready0, ready1, out_valid, out_data, out_src, out_last
  );

endinterface

// File: rtl/_32bit_2mux.sv
// 32-bit two-input multiplexer: y = select ? b : a.
module _32bit_2mux (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        select,
  output logic [31:0] y
);

  // Plain two-way data select
  always_comb begin
    if (select) begin
      y = b;
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Two-requester round-robin arbiter with burst lock, forced release after
// MAX_BURST beats and a single registered output stage.
module shared_bus_arbiter
  import shared_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  shared_bus_arbiter_if.slave  bus
);

  localparam logic [7:0] BURST_LAST_IDX = 8'(MAX_BURST - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              rr_last_r;
  logic [7:0]        beat_cnt_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_src_r;
  logic              out_last_r;

  logic              grant_src_s;
  logic              can_load_s;
  logic              ready0_s;
  logic              ready1_s;
  logic              xfer_s;
  logic              release_s;
  logic [DATA_W-1:0] mux_data_s;
  beat_t             sel_beat_s;

  _32bit_2mux u_data_mux (
    .a      (bus.data0),
    .b      (bus.data1),
    .select (grant_src_s),
    .y      (mux_data_s)
  );

  // Handshake decode: the output register may take a beat when empty or draining
  always_comb begin
    grant_src_s = (state_r == ST_GRANT1);
    can_load_s  = (!out_valid_r) || bus.out_ready;
    ready0_s    = (state_r == ST_GRANT0) && can_load_s;
    ready1_s    = (state_r == ST_GRANT1) && can_load_s;
    sel_beat_s.data = mux_data_s;
    if (grant_src_s) begin
      sel_beat_s.last = bus.last1;
      xfer_s          = bus.valid1 && ready1_s;
    end else begin
      sel_beat_s.last = bus.last0;
      xfer_s          = bus.valid0 && ready0_s;
    end
    release_s = xfer_s && (sel_beat_s.last || burst_full(beat_cnt_r, BURST_LAST_IDX));
  end

  // Next-state: ties in IDLE go to the requester not served last
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid0 && bus.valid1) begin
          state_nxt_s = rr_last_r ? ST_GRANT0 : ST_GRANT1;
        end else if (bus.valid0) begin
          state_nxt_s = ST_GRANT0;
        end else if (bus.valid1) begin
          state_nxt_s = ST_GRANT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM, per-grant beat counter and round-robin memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rr_last_r  <= 1'b1;
      beat_cnt_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_IDLE) || release_s) begin
        beat_cnt_r <= 8'd0;
      end else if (xfer_s) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (release_s) begin
        rr_last_r <= grant_src_s;
      end else begin
        rr_last_r <= rr_last_r;
      end
    end
  end

  // Output register: fill on transfer, drop valid only on a drain with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_beat_s.data;
      out_src_r   <= grant_src_s;
      out_last_r  <= sel_beat_s.last || burst_full(beat_cnt_r, BURST_LAST_IDX);
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.ready0    = ready0_s;
  assign bus.ready1    = ready1_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: per-cycle compare against a
// transaction-level model plus literal checks of the delivered beat order.
module tb_shared_bus_arbiter;

  localparam int MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  shared_bus_arbiter_if bus();

  shared_bus_arbiter #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic last; } src_beat_t;
  typedef struct { logic [31:0] data; logic src; logic last; int cyc; } obs_t;

  src_beat_t q0[$];
  src_beat_t q1[$];
  obs_t      log_q[$];
  obs_t      exp_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit pause0  = 1'b0;
  bit pause1  = 1'b0;
  bit ordy    = 1'b1;
  bit rst_req = 1'b0;

  // model: owner -1 = nobody granted
  int          m_owner;
  int          m_rr;
  int          m_cnt;
  bit          m_ov;
  logic [31:0] m_od;
  bit          m_os;
  bit          m_ol;

  function automatic void model_reset();
    m_owner = -1; m_rr = 1; m_cnt = 0;
    m_ov = 1'b0; m_od = 32'h0; m_os = 1'b0; m_ol = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int who, input logic [31:0] d, input logic l);
    src_beat_t b;
    b.data = d; b.last = l;
    if (who == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic expb(input logic [31:0] d, input logic s, input logic l);
    obs_t o;
    o.data = d; o.src = s; o.last = l; o.cyc = 0;
    exp_q.push_back(o);
  endtask

  // one clock: drive at negedge, compare at negedge+1, advance model
  task automatic step();
    bit er0, er1, v0, v1, acc;
    logic [31:0] d0, d1;
    bit l0, l1;
    int nxt;
    @(negedge clk);
    rst_n = rst_req;
    v0 = (q0.size() > 0) && !pause0;
    v1 = (q1.size() > 0) && !pause1;
    d0 = v0 ? q0[0].data : 32'h0;  l0 = v0 ? q0[0].last : 1'b0;
    d1 = v1 ? q1[0].data : 32'h0;  l1 = v1 ? q1[0].last : 1'b0;
    bus.valid0 = v0; bus.data0 = d0; bus.last0 = l0;
    bus.valid1 = v1; bus.data1 = d1; bus.last1 = l1;
    bus.out_ready = ordy;
    if (!rst_n) model_reset();
    #1;
    er0 = (m_owner == 0) && (!m_ov || ordy);
    er1 = (m_owner == 1) && (!m_ov || ordy);
    chk("ready0", 32'(bus.ready0), 32'(er0));
    chk("ready1", 32'(bus.ready1), 32'(er1));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov || !rst_n) begin
      chk("out_data", bus.out_data, m_od);
      chk("out_src", 32'(bus.out_src), 32'(m_os));
      chk("out_last", 32'(bus.out_last), 32'(m_ol));
    end
    if (rst_n && bus.out_valid && ordy)
      log_q.push_back('{bus.out_data, bus.out_src, bus.out_last, cyc});
    if (rst_n) begin
      nxt = m_owner;
      acc = (m_owner == 0 && v0 && er0) || (m_owner == 1 && v1 && er1);
      if (m_owner == -1) begin
        m_cnt = 0;
        if (v0 && v1) nxt = 1 - m_rr;
        else if (v0)  nxt = 0;
        else if (v1)  nxt = 1;
      end
      if (acc) begin
        m_cnt++;
        m_od = (m_owner == 1) ? d1 : d0;
        m_os = (m_owner == 1);
        m_ol = ((m_owner == 1) ? l1 : l0) || (m_cnt == MB);
        m_ov = 1'b1;
        if (m_ol) begin
          nxt = -1; m_rr = m_owner; m_cnt = 0;
        end
        if (m_owner == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      m_owner = nxt;
    end
    cyc++;
  endtask

  task automatic drain(input int max, input bit need_idle);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_ov || (need_idle && m_owner != -1)) && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= max), 32'h0);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_data"}, log_q[i].data, exp_q[i].data);
      chk({tag, "_src"},  32'(log_q[i].src),  32'(exp_q[i].src));
      chk({tag, "_last"}, 32'(log_q[i].last), 32'(exp_q[i].last));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0;
    bus.valid0 = 1'b0; bus.valid1 = 1'b0; bus.data0 = 32'h0; bus.data1 = 32'h0;
    bus.last0 = 1'b0; bus.last1 = 1'b0; bus.out_ready = 1'b1;
    model_reset();

    // reset with both requesters already presenting 3-beat bursts
    rst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(0, 32'hA0 + 32'(i), (i == 2));
      push(1, 32'hB0 + 32'(i), (i == 2));
    end
    repeat (3) step();
    chk("rst_ready0_lit", 32'(bus.ready0), 32'h0);
    chk("rst_out_data_lit", bus.out_data, 32'h0);

    // tie from reset: requester 0 first, one idle cycle between grants
    rst_req = 1'b1;
    t0 = cyc;
    drain(40, 1'b1);
    if (log_q.size() >= 4) begin
      chk("tie_first_latency", 32'(log_q[0].cyc - t0), 32'd2);
      chk("tie_gap", 32'(log_q[3].cyc - log_q[2].cyc), 32'd2);
    end else begin
      chk("tie_log_short", 32'(log_q.size()), 32'd6);
    end
    expb(32'hA0, 1'b0, 1'b0); expb(32'hA1, 1'b0, 1'b0); expb(32'hA2, 1'b0, 1'b1);
    expb(32'hB0, 1'b1, 1'b0); expb(32'hB1, 1'b1, 1'b0); expb(32'hB2, 1'b1, 1'b1);
    check_log("tie");

    // round robin: after requester 0 finishes, a tie goes to requester 1
    push(0, 32'hC0, 1'b0); push(0, 32'hC1, 1'b1);
    drain(20, 1'b1);
    push(0, 32'hD0, 1'b1); push(1, 32'hD1, 1'b1);
    drain(20, 1'b1);
    expb(32'hC0, 1'b0, 1'b0); expb(32'hC1, 1'b0, 1'b1);
    expb(32'hD1, 1'b1, 1'b1); expb(32'hD0, 1'b0, 1'b1);
    check_log("rr");

    // backpressure: out_ready low 4 cycles mid-burst
    push(0, 32'hE0, 1'b0); push(0, 32'hE1, 1'b0); push(0, 32'hE2, 1'b1);
    repeat (3) step();
    ordy = 1'b0;
    repeat (4) step();
    #1;
    chk("bp_frozen_data", bus.out_data, 32'hE1);
    chk("bp_ready0", 32'(bus.ready0), 32'h0);
    ordy = 1'b1;
    drain(20, 1'b1);
    expb(32'hE0, 1'b0, 1'b0); expb(32'hE1, 1'b0, 1'b0); expb(32'hE2, 1'b0, 1'b1);
    check_log("bp");

    // burst lock: requester 0 pauses 3 cycles while requester 1 waits
    push(0, 32'h70, 1'b0); push(0, 32'h71, 1'b0); push(0, 32'h72, 1'b1);
    repeat (3) step();
    push(1, 32'h80, 1'b1);
    pause0 = 1'b1;
    repeat (3) step();
    #1;
    chk("lock_ready1", 32'(bus.ready1), 32'h0);
    chk("lock_q1_pending", 32'(q1.size()), 32'd1);
    pause0 = 1'b0;
    drain(20, 1'b1);
    expb(32'h70, 1'b0, 1'b0); expb(32'h71, 1'b0, 1'b0); expb(32'h72, 1'b0, 1'b1);
    expb(32'h80, 1'b1, 1'b1);
    check_log("lock");

    // forced release after MB=4 beats, remainder in the next grant
    for (int i = 0; i < 6; i++) push(0, 32'hF0 + 32'(i), 1'b0);
    drain(40, 1'b0);
    if (log_q.size() >= 5) begin
      chk("force_gap", 32'(log_q[4].cyc - log_q[3].cyc), 32'd2);
    end else begin
      chk("force_log_short", 32'(log_q.size()), 32'd6);
    end
    expb(32'hF0, 1'b0, 1'b0); expb(32'hF1, 1'b0, 1'b0); expb(32'hF2, 1'b0, 1'b0);
    expb(32'hF3, 1'b0, 1'b1); expb(32'hF4, 1'b0, 1'b0); expb(32'hF5, 1'b0, 1'b0);
    check_log("force");

    // reset mid-burst with a held output beat
    ordy = 1'b0;
    push(0, 32'h5A5A_0001, 1'b0);
    repeat (2) step();
    #1;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
    @(negedge clk);
    rst_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_mid_ready0", 32'(bus.ready0), 32'h0);
    chk("rst_mid_ready1", 32'(bus.ready1), 32'h0);
    q0.delete();
    ordy = 1'b1;
    repeat (2) step();
    rst_req = 1'b1;
    push(0, 32'h90, 1'b1); push(1, 32'h91, 1'b1);
    drain(20, 1'b1);
    expb(32'h90, 1'b0, 1'b1); expb(32'h91, 1'b1, 1'b1);
    check_log("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shared_bus_arbiter.md
SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 16, maximum beats per grant before forced release (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid0, valid1  input  1 each  requester i presents a beat.
REQ-005 data0, data1  input  32 each  requester i beat data.
REQ-006 last0, last1  input  1 each  final beat of requester i burst.
REQ-007 ready0, ready1  output  1 each  beat of requester i accepted this cycle when valid_i high.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a beat.
REQ-010 out_data  output  32  registered selected data.
REQ-011 out_src  output  1  requester that produced out_data (0 or 1).
REQ-012 out_last  output  1  out_data is the final beat of its burst (requester last or forced release).

Function
REQ-013 State machine: IDLE, GRANT0, GRANT1; one-hot or binary encoding, implementer's choice.
REQ-014 IDLE: valid0 only -> GRANT0; valid1 only -> GRANT1; both -> grant requester opposite to rr_last; neither -> stay IDLE.
REQ-015 Arbitration latency: valid_i first seen in IDLE at cycle N -> grant active at N+1; first beat earliest accepted at N+1; out_valid earliest at N+2.
REQ-016 ready_i = (state == GRANTi) && (!out_valid || out_ready); ready of non-granted requester 0.
REQ-017 Beat transfer on valid_i && ready_i: out_data <= data_i, out_src <= i, out_valid <= 1, out_last <= last_i || (beat_cnt == MAX_BURST-1).
REQ-018 out_valid cleared when out_ready && out_valid and no new beat transferred same cycle; simultaneous drain and fill keeps out_valid 1 with new data (no bubble).
REQ-019 out_data, out_src, out_last stable while out_valid && !out_ready.
REQ-020 beat_cnt (8 bits) counts accepted beats in current grant; cleared on entry to IDLE.
REQ-021 GRANTi -> IDLE on transfer with last_i, or on transfer making beat_cnt reach MAX_BURST; rr_last <= i at that edge.
REQ-022 valid_i low during GRANTi without last: grant held (burst lock), no timeout.
REQ-023 valid_i of non-granted requester ignored until IDLE; no beat of it lost (ready stays 0).
REQ-024 Return to IDLE costs one cycle; back-to-back bursts from alternating requesters therefore have one idle cycle between grants.

Reset
REQ-025 While rst_n low: state IDLE, rr_last 1 (requester 0 wins first tie), beat_cnt 0, out_valid 0, out_data 0, out_src 0, out_last 0, ready0/ready1 0.
REQ-026 Reset assertion mid-burst discards held beat and grant immediately, no handshake completion required.
REQ-027 First grant possible on first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package holds state encoding constants and DATA_W = 32; MAX_BURST stays a module parameter.
REQ-029 Data selection uses one instance of existing _32bit_2mux (a = data0, b = data1, select = granted requester) feeding the output register; no other sub-modules.

Verification
REQ-030 Reset: rst_n low mid-burst with out_valid 1 -> out_valid 0, ready0/1 0, state IDLE same cycle.
REQ-031 Tie: both valid from reset, 3-beat bursts 0xA0..0xA2 / 0xB0..0xB2, out_ready 1 -> out sequence A0,A1,A2 (src 0, last on A2), one idle cycle, B0,B1,B2 (src 1).
REQ-032 Round-robin: requester 0 finishes burst, both then valid -> requester 1 granted next.
REQ-033 Backpressure: out_ready low 4 cycles during burst -> ready_i 0, out_data frozen, no beat dropped or duplicated.
REQ-034 Forced release: MAX_BURST=4, requester 0 sends 6 beats no last -> 4th beat out_last 1, grant released, remaining beats delivered in next grant.
REQ-035 Lock: granted requester drops valid 3 cycles mid-burst while other valid -> no grant switch, other ready stays 0.
